// File: rtl/instr_fetch.sv
// Instruction fetch stage: program counter, loadable instruction memory and
// instruction register feeding the Controller's decode logic.
module instr_fetch #(
  parameter int unsigned PC_W = 7,
  parameter int unsigned IR_W = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            pc_clr,
  input  logic            pc_up,
  input  logic            ld,
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [IR_W-1:0] prog_data,
  output logic [IR_W-1:0] instruction,
  output logic [PC_W-1:0] pc_o,
  output logic            ir_valid,
  output logic            wrap
);

  localparam int unsigned DEPTH = 2 ** PC_W;

  logic [IR_W-1:0] mem [DEPTH];
  logic [IR_W-1:0] rd_c;
  logic [PC_W-1:0] pc_nxt_c;
  logic            wrap_nxt_c;

  // Asynchronous memory read at the current PC.
  assign rd_c = mem[pc_o];

  // Program-load port; storage is not reset so a program survives reset.
  // Nonblocking write gives read-before-write against a same-edge ld.
  always_ff @(posedge clock) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Next PC and wrap flag: clear beats increment, increment past the top sets wrap.
  always_comb begin
    pc_nxt_c   = pc_o;
    wrap_nxt_c = wrap;
    if (pc_clr) begin
      pc_nxt_c   = '0;
      wrap_nxt_c = 1'b0;
    end else if (pc_up) begin
      pc_nxt_c = pc_o + PC_W'(1);
      if (&pc_o) begin
        wrap_nxt_c = 1'b1;
      end
    end
  end

  // PC and sticky wrap registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_o <= '0;
      wrap <= 1'b0;
    end else begin
      pc_o <= pc_nxt_c;
      wrap <= wrap_nxt_c;
    end
  end

  // Instruction register loads the word at the pre-edge PC.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instruction <= '0;
      ir_valid    <= 1'b0;
    end else if (ld) begin
      instruction <= rd_c;
      ir_valid    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table plus hand-written sequences
// for reset, wrap-around and memory persistence.
module tb_instr_fetch;

  logic        clock;
  logic        reset;
  logic        pc_clr;
  logic        pc_up;
  logic        ld;
  logic        prog_we;
  logic [6:0]  prog_addr;
  logic [15:0] prog_data;
  logic [15:0] instruction;
  logic [6:0]  pc_o;
  logic        ir_valid;
  logic        wrap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        clr;
    logic        up;
    logic        ld;
    logic        we;
    logic [6:0]  addr;
    logic [15:0] data;
    logic [15:0] exp_instr;
    logic [6:0]  exp_pc;
    logic        exp_valid;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs[$];

  instr_fetch #(.PC_W(7), .IR_W(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .pc_clr      (pc_clr),
    .pc_up       (pc_up),
    .ld          (ld),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .instruction (instruction),
    .pc_o        (pc_o),
    .ir_valid    (ir_valid),
    .wrap        (wrap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] ei, input logic [6:0] ep,
                         input logic ev, input logic ew);
    chk({tag, " instruction"}, 32'(instruction), 32'(ei));
    chk({tag, " pc_o"}, 32'(pc_o), 32'(ep));
    chk({tag, " ir_valid"}, 32'(ir_valid), 32'(ev));
    chk({tag, " wrap"}, 32'(wrap), 32'(ew));
  endtask

  // Called at a falling edge: drive strobes across one rising edge, then idle.
  task automatic step(input logic c, input logic u, input logic l, input logic w,
                      input logic [6:0] a, input logic [15:0] d);
    pc_clr = c; pc_up = u; ld = l; prog_we = w; prog_addr = a; prog_data = d;
    @(negedge clock);
    pc_clr = 1'b0; pc_up = 1'b0; ld = 1'b0; prog_we = 1'b0;
    prog_addr = '0; prog_data = '0;
  endtask

  task automatic add(input logic c, input logic u, input logic l, input logic w,
                     input logic [6:0] a, input logic [15:0] d,
                     input logic [15:0] ei, input logic [6:0] ep,
                     input logic ev, input logic ew);
    vec_t v;
    v.clr = c; v.up = u; v.ld = l; v.we = w; v.addr = a; v.data = d;
    v.exp_instr = ei; v.exp_pc = ep; v.exp_valid = ev; v.exp_wrap = ew;
    vecs.push_back(v);
  endtask

  // Mid-cycle asynchronous reset pulse, checked before the next rising edge.
  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1 chk_all(tag, 16'h0000, 7'd0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clock);
  endtask

  logic [15:0] prog [6];

  initial begin
    prog[0] = 16'h20A1; prog[1] = 16'h21A2; prog[2] = 16'h2033;
    prog[3] = 16'h28A4; prog[4] = 16'h4125; prog[5] = 16'h6006;

    reset = 1'b0; pc_clr = 1'b0; pc_up = 1'b0; ld = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;

    @(negedge clock);
    chk_all("reset_state", 16'h0000, 7'd0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 7'(i), prog[i]);
    chk_all("after_program", 16'h0000, 7'd0, 1'b0, 1'b0);

    // Move off reset state, then reset mid-cycle.
    step(1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 16'h0);
    chk_all("pre_reset_fetch", 16'h20A1, 7'd1, 1'b1, 1'b0);
    async_reset("midcycle_reset");
    step(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 16'h0);
    chk_all("first_ld_after_reset", 16'h20A1, 7'd0, 1'b1, 1'b0);

    // Vector table: Controller-like fetch pattern, priority, read-before-write.
    add(0,1,1,0,7'd0,16'h0,    16'h20A1, 7'd1, 1, 0);
    add(0,0,0,0,7'd0,16'h0,    16'h20A1, 7'd1, 1, 0);
    add(0,0,0,0,7'd0,16'h0,    16'h20A1, 7'd1, 1, 0);
    add(0,0,0,0,7'd0,16'h0,    16'h20A1, 7'd1, 1, 0);
    add(0,1,1,0,7'd0,16'h0,    16'h21A2, 7'd2, 1, 0);
    add(0,0,0,0,7'd0,16'h0,    16'h21A2, 7'd2, 1, 0);
    add(0,0,0,0,7'd0,16'h0,    16'h21A2, 7'd2, 1, 0);
    add(0,0,0,0,7'd0,16'h0,    16'h21A2, 7'd2, 1, 0);
    add(0,1,1,0,7'd0,16'h0,    16'h2033, 7'd3, 1, 0);
    add(0,1,1,0,7'd0,16'h0,    16'h28A4, 7'd4, 1, 0);
    add(0,1,1,0,7'd0,16'h0,    16'h4125, 7'd5, 1, 0);
    add(1,1,1,0,7'd0,16'h0,    16'h6006, 7'd0, 1, 0);
    add(0,1,0,0,7'd0,16'h0,    16'h6006, 7'd1, 1, 0);
    add(0,1,0,0,7'd0,16'h0,    16'h6006, 7'd2, 1, 0);
    add(0,1,0,0,7'd0,16'h0,    16'h6006, 7'd3, 1, 0);
    add(0,0,1,1,7'd3,16'h5000, 16'h28A4, 7'd3, 1, 0);
    add(0,0,1,0,7'd0,16'h0,    16'h5000, 7'd3, 1, 0);
    add(1,0,0,0,7'd0,16'h0,    16'h5000, 7'd0, 1, 0);
    add(0,0,1,0,7'd0,16'h0,    16'h20A1, 7'd0, 1, 0);

    foreach (vecs[i]) begin
      step(vecs[i].clr, vecs[i].up, vecs[i].ld, vecs[i].we, vecs[i].addr, vecs[i].data);
      chk_all($sformatf("vec%0d", i), vecs[i].exp_instr, vecs[i].exp_pc,
              vecs[i].exp_valid, vecs[i].exp_wrap);
    end

    // Wrap-around and sticky flag.
    for (int i = 0; i < 127; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 16'h0);
    chk_all("at_top", 16'h20A1, 7'd127, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 16'h0);
    chk_all("wrap_edge", 16'h20A1, 7'd0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 16'h0);
    chk_all("wrap_sticky", 16'h20A1, 7'd1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 16'h0);
    chk_all("wrap_cleared", 16'h20A1, 7'd0, 1'b1, 1'b0);

    // pc_clr beats pc_up on the wrap edge.
    for (int i = 0; i < 127; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 16'h0);
    chk_all("at_top_again", 16'h20A1, 7'd127, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 16'h0);
    chk_all("clr_on_wrap_edge", 16'h20A1, 7'd0, 1'b1, 1'b0);

    // Memory survives reset.
    step(0,1,1,0,7'd0,16'h0);
    step(0,1,1,0,7'd0,16'h0);
    chk_all("run_before_reset", 16'h21A2, 7'd2, 1'b1, 1'b0);
    async_reset("persist_reset");
    step(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 16'h0);
    chk_all("persist_mem0", 16'h20A1, 7'd0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 16'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 16'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 16'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 16'h0);
    chk_all("persist_mem3", 16'h5000, 7'd3, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the LabB processor, directly upstream of the FSM `Controller`. It holds the program counter, a loadable instruction memory and the instruction register (IR). It responds to the Controller's `pc_clr`, `pc_up` and `ld` strobes and drives the 16-bit `instruction` bus the Controller decodes. A program-load write port lets the bench or board logic fill the memory before the processor runs.

## Interface
Parameters:
- `PC_W`, default 7: program counter width; the memory depth is 2**PC_W words.
- `IR_W`, default 16: instruction width.

Ports:
- `clock`, in, 1: the single system clock; all state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `pc_clr`, in, 1: from Controller; clears the PC.
- `pc_up`, in, 1: from Controller; increments the PC.
- `ld`, in, 1: from Controller; loads the IR with the memory word at the PC.
- `prog_we`, in, 1: program-load write enable.
- `prog_addr`, in, PC_W: program-load address.
- `prog_data`, in, IR_W: program-load data.
- `instruction`, out, IR_W: IR contents, to Controller.
- `pc_o`, out, PC_W: current PC, for debug/display.
- `ir_valid`, out, 1: IR has been loaded at least once since reset.
- `wrap`, out, 1: sticky flag; the PC has rolled over from 2**PC_W-1 to 0.

## Operation
- Registers: PC (PC_W bits), IR (IR_W bits), `ir_valid`, `wrap`, and memory `mem[0..2**PC_W-1]`.
- Reset (`reset`=0, asynchronous): PC=0, IR=16'h0000 (NOOP), `ir_valid`=0, `wrap`=0. Memory contents are not reset and are preserved across reset.
- Memory read is combinational: `rd = mem[PC]`.
- IR update: if `ld`=1, IR<=`rd` using the PC value before this edge, and `ir_valid`<=1. Otherwise IR holds.
- PC update, in priority order:
  - `pc_clr`=1: PC<=0 and `wrap`<=0. This overrides `pc_up`.
  - Otherwise, `pc_up`=1: PC<=PC+1, modulo 2**PC_W. If PC was 2**PC_W-1, PC becomes 0 and `wrap`<=1.
  - Otherwise: PC holds.
- `ld` is independent of the PC strobes. `ld`+`pc_up` on the same edge (the Controller's Fetch state) loads mem[PC] and then advances the PC.
- `ld`+`pc_clr` on the same edge loads mem[old PC] while the PC clears.
- Program write: if `prog_we`=1, mem[`prog_addr`]<=`prog_data`.
  - Read-before-write: if `ld` reads the same address on the same edge, the IR gets the old word.
  - The written word is visible to `rd` from the next cycle.
- `prog_we` is allowed at any time, including while the Controller runs. The block does no arbitration.
- No internal FSM gates the strobes; sequencing is owned by the Controller.

## Timing
- `instruction`, `pc_o`, `ir_valid` and `wrap` are register outputs. They change only on a rising `clock` edge or on assertion of `reset`.
- Fetch latency is 1 cycle: `ld` sampled high at edge N makes mem[PC(N-1)] appear on `instruction` after edge N.
- A Controller Fetch→Decode sequence therefore sees a stable `instruction` for the whole Decode cycle.
- PC change latency is 1 cycle; `pc_o` reflects the new value after the edge.
- Reset asserted mid-operation takes effect immediately and asynchronously; any strobe in that cycle is lost.
- After reset is released, the first edge with `ld`=1 loads mem[0].
- Wrap-around at PC=2**PC_W-1 with `pc_up` gives PC=0 and `wrap`=1 in the same cycle.
- `pc_clr` and `pc_up` on the wrap edge: `pc_clr` wins, so `wrap` stays 0.

## Test plan
- Reset: preload mem[0]=16'h20A1; drive `reset`=0 mid-cycle → immediately PC=0, `instruction`=16'h0000, `ir_valid`=0, `wrap`=0. Release, pulse `ld` → `instruction`=16'h20A1, `ir_valid`=1.
- Sequential fetch: load mem[0..4]=20A1, 21A2, 2033, 28A4, 4125. Assert `ld`+`pc_up` every 4th cycle (Controller-like pattern) → `instruction` steps through those words in order, `pc_o`=1..5.
- Priority: at PC=5, assert `pc_clr`+`pc_up`+`ld` together → `instruction`=mem[5], PC=0, `wrap`=0.
- Wrap: with PC_W=7, advance to PC=127 and pulse `pc_up` → PC=0, `wrap`=1. Then pulse `pc_clr` → `wrap`=0.
- Read-before-write: at PC=3, assert `prog_we` (addr 3, data 16'h5000) together with `ld` → IR=old mem[3]=16'h28A4. Re-fetch at PC=3 → 16'h5000.
- Reset persistence: after a program run, pulse `reset` → PC=0. Then `ld` returns the previously programmed mem[0]=16'h20A1, showing the memory is not cleared.
